// File: rtl/rotate_shift_pkg.sv
// Shared types for the rotate/shift engine: operation modes and FSM states.
package rotate_shift_pkg;

    // Operation select as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_ROR = 2'b01,
        MODE_SLL = 2'b10,
        MODE_SRA = 2'b11
    } mode_e;

    // Control FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rotate_shift_step.sv
// Single-position step: next register value and the bit that leaves the
// register, for the currently latched operation.
module rotate_shift_step
    import rotate_shift_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] q,
    input  mode_e         mode,
    output logic [DW-1:0] q_next,
    output logic          ser_next
);

    logic signed [DW-1:0] q_s;

    assign q_s = q;

    // Select the one-position result and the departing bit for each mode.
    always_comb begin
        q_next   = q;
        ser_next = 1'b0;
        case (mode)
            MODE_ROL: begin
                q_next   = {q[DW-2:0], q[DW-1]};
                ser_next = q[DW-1];
            end
            MODE_ROR: begin
                q_next   = {q[0], q[DW-1:1]};
                ser_next = q[0];
            end
            MODE_SLL: begin
                q_next   = {q[DW-2:0], 1'b0};
                ser_next = q[DW-1];
            end
            MODE_SRA: begin
                // Sign bit is replicated into the vacated MSB.
                q_next   = $unsigned(q_s >>> 1);
                ser_next = q[0];
            end
            default: begin
                q_next   = q;
                ser_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rotate_shift_engine.sv
// Command-driven rotate/shift register: parallel load, then ROL/ROR/SLL/SRA
// by a variable number of positions, one position per clock, with a
// start/busy/done handshake and abort.
module rotate_shift_engine
    import rotate_shift_pkg::*;
#(
    parameter  int DW = 8,
    localparam int AW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          abort,
    output logic [DW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic          ser_out
);

    state_e        state;
    state_e        state_nxt;
    mode_e         mode_r;
    logic [AW-1:0] cnt;
    logic          done_pend;

    logic          take_load;
    logic          take_run;
    logic          take_zero;
    logic          take_step;
    logic          last_step;

    logic [DW-1:0] q_step;
    logic          ser_step;

    rotate_shift_step #(
        .DW(DW)
    ) u_step (
        .q        (q),
        .mode     (mode_r),
        .q_next   (q_step),
        .ser_next (ser_step)
    );

    // Next-state and per-cycle action decode; load wins over start in IDLE,
    // abort wins over the step (including the final one) in RUN.
    always_comb begin
        state_nxt = state;
        take_load = 1'b0;
        take_run  = 1'b0;
        take_zero = 1'b0;
        take_step = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    take_load = 1'b1;
                end else if (start) begin
                    if (amt == '0) begin
                        take_zero = 1'b1;
                    end else begin
                        take_run  = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    take_step = 1'b1;
                    if (cnt == AW'(1)) begin
                        last_step = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched command: operation and remaining step count.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            mode_r <= MODE_ROL;
            cnt    <= '0;
        end else if (take_run) begin
            mode_r <= mode_e'(mode);
            cnt    <= amt;
        end else if (take_step) begin
            cnt    <= cnt - AW'(1);
        end
    end

    // Data register and serial output; ser_out only moves on a step.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            q       <= '0;
            ser_out <= 1'b0;
        end else if (take_load) begin
            q       <= data;
        end else if (take_step) begin
            q       <= q_step;
            ser_out <= ser_step;
        end
    end

    // Completion pulse, delayed one cycle behind the completing edge.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            done_pend <= take_zero | last_step;
            done      <= done_pend;
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_rotate_shift_engine.sv
// Directed bench for rotate_shift_engine with a cycle-level reference model.
module tb_rotate_shift_engine;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          load;
    logic [DW-1:0] data;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic          abort;
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
    logic          ser_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotate_shift_engine #(.DW(DW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .load      (load),
        .data      (data),
        .start     (start),
        .mode      (mode),
        .amt       (amt),
        .abort     (abort),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .ser_out   (ser_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic description of one position of each operation.
    function automatic logic [DW-1:0] model_step(input logic [1:0] md, input logic [DW-1:0] v);
        case (md)
            2'd0:    return (v << 1) | (v >> (DW - 1));
            2'd1:    return (v >> 1) | (v << (DW - 1));
            2'd2:    return v << 1;
            default: return $signed(v) >>> 1;
        endcase
    endfunction

    function automatic logic model_ser(input logic [1:0] md, input logic [DW-1:0] v);
        return (md == 2'd0 || md == 2'd2) ? v[DW-1] : v[0];
    endfunction

    logic [DW-1:0] m_q         = '0;
    logic          m_ser       = 1'b0;
    logic          m_busy      = 1'b0;
    logic          m_done      = 1'b0;
    logic          m_done_next = 1'b0;
    logic [1:0]    m_mode      = 2'd0;
    int            m_left      = 0;

    always @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            m_q         <= '0;
            m_ser       <= 1'b0;
            m_busy      <= 1'b0;
            m_done      <= 1'b0;
            m_done_next <= 1'b0;
            m_left      <= 0;
        end else begin
            m_done      <= m_done_next;
            m_done_next <= 1'b0;
            if (!m_busy) begin
                if (load) begin
                    m_q <= data;
                end else if (start) begin
                    if (amt == 0) begin
                        m_done_next <= 1'b1;
                    end else begin
                        m_busy <= 1'b1;
                        m_left <= int'(amt);
                        m_mode <= mode;
                    end
                end
            end else if (abort) begin
                m_busy <= 1'b0;
            end else begin
                m_q    <= model_step(m_mode, m_q);
                m_ser  <= model_ser(m_mode, m_q);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy      <= 1'b0;
                    m_done_next <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_q", q, m_q);
        check("model_busy", busy, m_busy);
        check("model_done", done, m_done);
        check("model_ser", ser_out, m_ser);
    end

    task automatic do_load(input logic [DW-1:0] v);
        load = 1'b1;
        data = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] md, input int n, output int busy_cnt, output int done_cnt);
        mode  = md;
        amt   = AW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n + 4; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic count_done(input int n, output int done_cnt);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int b;
        int d;
        async_rst = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        data  = '0;
        mode  = 2'd0;
        amt   = '0;
        repeat (3) @(negedge clk);
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ser", ser_out, 1'b0);
        async_rst = 1'b0;
        @(negedge clk);

        // ROL by 3 from B4, watching each step.
        do_load(8'hB4);
        check("load_b4", q, 8'hB4);
        mode  = 2'd0;
        amt   = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rol3_busy_e0", busy, 1'b1);
        @(negedge clk);
        check("rol3_q1", q, 8'h69);
        @(negedge clk);
        check("rol3_q2", q, 8'hD2);
        @(negedge clk);
        check("rol3_q3", q, 8'hA5);
        check("rol3_busy_end", busy, 1'b0);
        check("rol3_ser", ser_out, 1'b1);
        check("rol3_no_early_done", done, 1'b0);
        @(negedge clk);
        check("rol3_done", done, 1'b1);
        @(negedge clk);
        check("rol3_done_pulse", done, 1'b0);

        do_load(8'h81);
        run_cmd(2'd1, 7, b, d);
        check("ror7_q", q, 8'h03);
        check("ror7_busy_cycles", b, 7);
        check("ror7_done_cnt", d, 1);

        do_load(8'h90);
        run_cmd(2'd3, 2, b, d);
        check("sra2_q", q, 8'hE4);

        do_load(8'hFF);
        run_cmd(2'd2, 5, b, d);
        check("sll5_q", q, 8'hE0);
        check("sll5_ser", ser_out, 1'b1);

        // Zero-length command.
        run_cmd(2'd0, 0, b, d);
        check("amt0_q", q, 8'hE0);
        check("amt0_busy_cycles", b, 0);
        check("amt0_done_cnt", d, 1);

        // Load and start together: load wins, start dropped.
        load  = 1'b1;
        start = 1'b1;
        data  = 8'h5A;
        mode  = 2'd0;
        amt   = 3'd3;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        count_done(5, d);
        check("ldst_q", q, 8'h5A);
        check("ldst_busy", busy, 1'b0);
        check("ldst_done_cnt", d, 0);

        // Load ignored during RUN, then abort after two steps.
        do_load(8'h01);
        mode  = 2'd0;
        amt   = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        load  = 1'b0;
        check("run_load_ignored", q, 8'h02);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_q", q, 8'h04);
        check("abort_busy", busy, 1'b0);
        count_done(4, d);
        check("abort_done_cnt", d, 0);
        run_cmd(2'd0, 1, b, d);
        check("after_abort_q", q, 8'h08);
        check("after_abort_done_cnt", d, 1);

        // Abort coinciding with the final step.
        do_load(8'h01);
        mode  = 2'd0;
        amt   = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_last_q", q, 8'h02);
        check("abort_last_busy", busy, 1'b0);
        count_done(4, d);
        check("abort_last_done_cnt", d, 0);

        // Abort while idle does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_q", q, 8'h02);

        // New start accepted in the cycle done is high.
        do_load(8'h01);
        mode  = 2'd0;
        amt   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_q1", q, 8'h02);
        @(negedge clk);
        check("b2b_done1", done, 1'b1);
        mode  = 2'd1;
        amt   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy2", busy, 1'b1);
        @(negedge clk);
        check("b2b_q2", q, 8'h01);
        @(negedge clk);
        check("b2b_done2", done, 1'b1);

        // Asynchronous reset between clock edges mid-command.
        do_load(8'hAA);
        mode  = 2'd0;
        amt   = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        async_rst = 1'b1;
        #1;
        check("arst_q", q, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_ser", ser_out, 1'b0);
        @(negedge clk);
        async_rst = 1'b0;
        @(negedge clk);
        do_load(8'h0F);
        run_cmd(2'd0, 4, b, d);
        check("post_rst_q", q, 8'hF0);
        check("post_rst_done_cnt", d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotate_shift_engine.md
# rotate_shift_engine

Parametrised multi-mode rotate/shift register. It replaces the fixed single-step left rotator in the register library with a command-driven unit that performs left/right rotates, logical left shifts and arithmetic right shifts. Each command runs a variable number of positions, one position per clock. The engine sits between a datapath load source and downstream consumers that need a start/busy/done handshake rather than a free-running enable.

## Interface
- DW, default 8: data width; legal range DW >= 2.
- AW, derived as $clog2(DW): width of the shift-amount field; not overridden by the instantiator.
- clk  input  1  rising-edge clock.
- async_rst  input  1  reset, asynchronous, active-high; clock clk.
- load  input  1  parallel load request; honoured in IDLE only.
- data  input  DW  parallel load value.
- start  input  1  command request; honoured in IDLE only.
- mode  input  2  operation select: 00 ROL, 01 ROR, 10 SLL, 11 SRA.
- amt  input  AW  number of single-position steps, 0 to DW-1.
- abort  input  1  cancels a running command.
- q  output  DW  register contents.
- busy  output  1  high while a command is running.
- done  output  1  one-cycle pulse when a command completes.
- ser_out  output  1  bit that left the MSB/LSB end on the most recent step.

## Operation
- States: IDLE and RUN. Reset values: state IDLE, q = 0, busy = 0, done = 0, ser_out = 0.
- IDLE, load = 1: q <= data. Load has priority; a simultaneous start is dropped, with no done pulse.
- IDLE, start = 1, load = 0, amt = 0: q is unchanged, done pulses on the next cycle, busy stays 0.
- IDLE, start = 1, load = 0, amt > 0: latch mode into mode_r and amt into cnt, then go to RUN.
- RUN, each cycle:
  - Apply one step per mode_r and decrement cnt.
  - When cnt reaches 1, perform the final step, go to IDLE and assert done the following cycle.
- Step definitions:
  - ROL: q <= {q[DW-2:0], q[DW-1]}, ser_out <= q[DW-1].
  - ROR: q <= {q[0], q[DW-1:1]}, ser_out <= q[0].
  - SLL: q <= {q[DW-2:0], 1'b0}, ser_out <= q[DW-1].
  - SRA: q <= {q[DW-1], q[DW-1:1]}, ser_out <= q[0].
- ser_out changes only on steps. It holds its value across IDLE and load.
- The mode and amt inputs are ignored after acceptance; mode_r and cnt are internal.
- load and start are ignored while busy; no queueing.
- RUN, abort = 1: return to IDLE at that edge with no step taken. q keeps its partial result, no done.
- abort in IDLE has no effect.
- abort and the final step in the same cycle: abort wins, so the final step is not taken and done is not asserted.
- async_rst at any time returns everything to reset values immediately, without waiting for a clock edge.

## Timing
- start is accepted at edge 0. busy = 1 after edge 0.
- Steps occur on edges 1..amt. After edge amt, q holds the final value and busy = 0.
- done = 1 for exactly the cycle after edge amt+1. Total latency is amt+1 edges to the final q and amt+2 edges to the done pulse.
- A new start is accepted in the same cycle done is high.
- For amt = 0, done is high after edge 1.
- load takes effect at the next edge, one-cycle latency.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package rotate_shift_pkg holds:
  - the mode_e enum (MODE_ROL = 2'b00, MODE_ROR = 2'b01, MODE_SLL = 2'b10, MODE_SRA = 2'b11);
  - the state_e enum (ST_IDLE, ST_RUN).
- Sub-module rotate_shift_step (combinational, parameter DW) computes the next q and ser_out from q and mode_r.
- The top level holds the FSM, cnt, mode_r and the output registers.

## Test plan
- DW = 8. Load 8'hB4, then start ROL with amt = 3.
  - q steps through 69, D2, A5. busy is high for 3 cycles and done pulses once.
  - Final ser_out = 1.
- Load 8'h81, then ROR with amt = 7: final q = 8'h03, done asserted once.
- Load 8'h90, then SRA with amt = 2: final q = 8'hE4.
- Load 8'hFF, then SLL with amt = 5: final q = 8'hE0, ser_out = 1.
- start with amt = 0: done pulses next cycle, busy never rises, q unchanged.
- load and start in the same cycle: q = data, no done.
- Load 8'h01, ROL with amt = 5.
  - Pulse load with 8'hFF during RUN: it is ignored.
  - abort after 2 steps: q = 8'h04, busy falls, no done.
  - A following start executes normally.
- Assert async_rst mid-RUN between clock edges: q, busy, done and ser_out go to 0 immediately. After release, load 8'h0F and ROL amt = 4 gives 8'hF0.
